// File: rtl/riscv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_issue_ctrl
//
// Instruction buffer and issue sequencer for the R-type datapath. Words are
// loaded into an internal RAM while idle. A start request then walks the
// buffer in order. Each word is fetched, decoded into its R-type fields and
// offered to the ALU over a valid/ready handshake. The sequencer reports
// completion with a one-cycle done pulse. It stops in an error state when it
// fetches a word whose opcode is not R-type.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   clear           empty the buffer (IDLE) / leave ERROR
//   load_valid/load_data/load_ready   word load handshake (IDLE only)
//   start           run the buffered program (IDLE only)
//   issue_valid/issue_ready           issue handshake towards the ALU
//   opcode, rd, funct3, rs1, rs2, funct7   registered decoded fields
//   issue_pc        buffer index of the instruction being issued
//   instr_count     number of buffered words (0..DEPTH)
//   busy            fetching or issuing
//   done            one-cycle completion pulse
//   error           illegal opcode seen; err_pc holds its index
// ---------------------------------------------------------------------------
module riscv_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [AW-1:0]    issue_pc,
  output logic [AW:0]      instr_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AW-1:0]    err_pc
);

  localparam logic [6:0]    OP_RTYPE  = 7'b0110011;
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_reg, state_next;
  logic [AW:0]      count_reg, count_next;
  logic [AW-1:0]    pc_reg, pc_next;
  logic [AW-1:0]    err_pc_reg, err_pc_next;
  logic [AW-1:0]    issue_pc_reg, issue_pc_next;
  logic [WIDTH-1:0] word_reg, word_next;

  // Instruction buffer: plain array with a registered read port so it maps
  // onto block RAM. Not reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  logic load_fire;
  logic last_instr;

  // pc is widened to count's width so a full buffer (count == DEPTH)
  // compares correctly against the last index.
  assign last_instr = ({1'b0, pc_reg} == (count_reg - CNT_ONE));
  assign load_fire  = load_valid && load_ready;

  // -------------------------------------------------------------------------
  // Buffer RAM
  // -------------------------------------------------------------------------
  // Loads only happen in IDLE, so the write port never collides with a fetch.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[count_reg[AW-1:0]] <= load_data;
    end
  end

  // The read address is the next pc. The word for a FETCH cycle is therefore
  // already in rd_data_reg when FETCH starts. The opcode check can then be
  // made in the FETCH cycle itself, keeping the 2-cycle issue cadence.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[pc_next];
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      pc_reg       <= '0;
      err_pc_reg   <= '0;
      issue_pc_reg <= '0;
      word_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      pc_reg       <= pc_next;
      err_pc_reg   <= err_pc_next;
      issue_pc_reg <= issue_pc_next;
      word_reg     <= word_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    pc_next       = pc_reg;
    err_pc_next   = err_pc_reg;
    issue_pc_next = issue_pc_reg;
    word_next     = word_reg;
    load_ready    = 1'b0;
    issue_valid   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // A word offered together with start or clear is not taken, so a
        // run never starts on a half-updated count.
        load_ready = (count_reg < CNT_FULL) && !start && !clear;
        if (clear) begin
          count_next = '0;
        end else if (start) begin
          pc_next = '0;
          if (count_reg == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_FETCH;
          end
        end else if (load_valid && (count_reg < CNT_FULL)) begin
          count_next = count_reg + CNT_ONE;
        end
      end

      S_FETCH: begin
        busy          = 1'b1;
        // Fields are captured even for an illegal word so the offending
        // encoding stays visible on the field outputs while in ERROR.
        word_next     = rd_data_reg;
        issue_pc_next = pc_reg;
        if (rd_data_reg[6:0] != OP_RTYPE) begin
          err_pc_next = pc_reg;
          state_next  = S_ERROR;
        end else begin
          state_next  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy        = 1'b1;
        issue_valid = 1'b1;
        if (issue_ready) begin
          if (last_instr) begin
            state_next = S_DONE;
          end else begin
            pc_next    = pc_reg + PC_ONE;
            state_next = S_FETCH;
          end
        end
      end

      S_DONE: begin
        done       = 1'b1;
        pc_next    = '0;
        state_next = S_IDLE;
      end

      S_ERROR: begin
        error = 1'b1;
        if (clear) begin
          count_next = '0;
          pc_next    = '0;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Field outputs: slices of the registered instruction word
  // -------------------------------------------------------------------------
  assign opcode      = word_reg[6:0];
  assign rd          = word_reg[11:7];
  assign funct3      = word_reg[14:12];
  assign rs1         = word_reg[19:15];
  assign rs2         = word_reg[24:20];
  assign funct7      = word_reg[31:25];
  assign issue_pc    = issue_pc_reg;
  assign err_pc      = err_pc_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_riscv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_issue_ctrl
//
// Directed bench for riscv_issue_ctrl. A behavioural model runs alongside
// the DUT. It works in terms of the buffered program, a run flag, and an
// "instruction offered" flag. Every cycle after reset, the DUT outputs are
// compared against this model. Hand-computed literals pin the model: decoded
// fields, issue order, done timing and error reporting.
// ---------------------------------------------------------------------------
module tb_riscv_issue_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst, clear, load_valid, start, issue_ready;
  logic [31:0]   load_data;
  logic          load_ready, issue_valid, busy, done, error;
  logic [6:0]    opcode, funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [AW-1:0] issue_pc, err_pc;
  logic [AW:0]   instr_count;

  always #5 clk = ~clk;

  riscv_issue_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .issue_pc(issue_pc), .instr_count(instr_count),
    .busy(busy), .done(done), .error(error), .err_pc(err_pc)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_buf [DEPTH];
  int          m_count   = 0;
  int          m_idx     = 0;
  bit          m_running = 1'b0;
  bit          m_offer   = 1'b0;
  bit          m_err     = 1'b0;
  bit          m_done    = 1'b0;
  logic [31:0] m_word    = 32'h0;
  int          m_ipc     = 0;
  int          m_epc     = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_count = 0; m_idx = 0; m_running = 0; m_offer = 0;
      m_err = 0; m_done = 0; m_word = 32'h0; m_ipc = 0; m_epc = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_err) begin
      if (clear) begin
        m_err = 0;
        m_count = 0;
      end
    end else if (m_running) begin
      if (!m_offer) begin
        m_word = m_buf[m_idx];
        m_ipc  = m_idx;
        if (m_word[6:0] != 7'b0110011) begin
          m_err = 1; m_epc = m_idx; m_running = 0;
        end else begin
          m_offer = 1;
        end
      end else if (issue_ready) begin
        m_offer = 0;
        if (m_idx == m_count - 1) begin
          m_running = 0;
          m_done = 1;
        end else begin
          m_idx++;
        end
      end
    end else begin
      if (clear) begin
        m_count = 0;
      end else if (start) begin
        if (m_count == 0) m_done = 1;
        else begin
          m_running = 1; m_idx = 0; m_offer = 0;
        end
      end else if (load_valid && m_count < DEPTH) begin
        m_buf[m_count] = load_data;
        m_count++;
      end
    end
  end

  // ---------------- compare / monitor ----------------
  logic [31:0] hs_word [$];
  int          hs_pc   [$];
  int          n_done  = 0;
  int          done_cyc = -1;
  int          n_acc   = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit idle;
      idle = !m_running && !m_err && !m_done;
      check("instr_count", 32'(instr_count), m_count);
      check("issue_valid", 32'(issue_valid), 32'(m_running && m_offer));
      check("busy", 32'(busy), 32'(m_running));
      check("done", 32'(done), 32'(m_done));
      check("error", 32'(error), 32'(m_err));
      check("load_ready", 32'(load_ready), 32'(idle && m_count < DEPTH && !start && !clear));
      check("err_pc", 32'(err_pc), m_epc);
      check("issue_pc", 32'(issue_pc), m_ipc);
      check("fields", {funct7, rs2, rs1, funct3, rd, opcode}, m_word);
      if (issue_valid && issue_ready) begin
        hs_word.push_back({funct7, rs2, rs1, funct3, rd, opcode});
        hs_pc.push_back(32'(issue_pc));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (load_valid && load_ready) n_acc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start(output int sc);
    sc    = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int nd;
    nd = n_done;
    for (int i = 0; i < budget; i++) begin
      if (n_done != nd || error) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL timeout: no done or error within %0d cycles", budget);
  endtask

  function automatic logic [31:0] mkw(input int i);
    int a;
    int b;
    a = i + 3;
    b = 31 - i;
    return {i[6:0], a[4:0], i[4:0], i[2:0], b[4:0], 7'b0110011};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int sc;
    int nd0;
    logic [31:0] w;

    rst = 1'b1; clear = 1'b0; load_valid = 1'b0; start = 1'b0;
    issue_ready = 1'b1; load_data = 32'h0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'd0);
    check("rst_pcs", {issue_pc, err_pc}, 32'd0);

    // Basic run
    load_word(32'h002081B3);
    load_word(32'h401182B3);
    hs_word.delete(); hs_pc.delete();
    do_start(sc);
    wait_end(20);
    $display("basic run: issues=%0d done_cyc=%0d start_cyc=%0d", hs_word.size(), done_cyc, sc);
    check("basic_issue_count", hs_word.size(), 32'd2);
    if (hs_word.size() >= 2) begin
      w = hs_word[0];
      check("basic_i0_rd", 32'(w[11:7]), 32'd3);
      check("basic_i0_rs1", 32'(w[19:15]), 32'd1);
      check("basic_i0_rs2", 32'(w[24:20]), 32'd2);
      check("basic_i0_funct7", 32'(w[31:25]), 32'd0);
      check("basic_i0_pc", hs_pc[0], 32'd0);
      w = hs_word[1];
      check("basic_i1_rd", 32'(w[11:7]), 32'd5);
      check("basic_i1_rs1", 32'(w[19:15]), 32'd3);
      check("basic_i1_rs2", 32'(w[24:20]), 32'd1);
      check("basic_i1_funct7", 32'(w[31:25]), 32'h20);
      check("basic_i1_pc", hs_pc[1], 32'd1);
    end
    check("basic_done_time", done_cyc, sc + 5);
    check("basic_count", 32'(instr_count), 32'd2);

    // Backpressure: issue_ready low for 4 cycles at issue 0
    tick();
    issue_ready = 1'b0;
    hs_word.delete(); hs_pc.delete();
    do_start(sc);
    tick();
    for (int k = 0; k < 4; k++) begin
      $display("backpressure hold cycle %0d: valid=%0d rd=%0d rs2=%0d pc=%0d", k, issue_valid, rd, rs2, issue_pc);
      check("bp_valid_held", 32'(issue_valid), 32'd1);
      check("bp_rd_held", 32'(rd), 32'd3);
      check("bp_rs2_held", 32'(rs2), 32'd2);
      check("bp_pc_held", 32'(issue_pc), 32'd0);
      tick();
    end
    issue_ready = 1'b1;
    wait_end(20);
    $display("backpressure: issues=%0d done_cyc=%0d start_cyc=%0d", hs_word.size(), done_cyc, sc);
    check("bp_done_time", done_cyc, sc + 9);
    check("bp_issue_count", hs_word.size(), 32'd2);

    // Illegal opcode at index 1
    tick();
    do_clear();
    load_word(32'h002081B3);
    load_word(32'h00108093);
    hs_word.delete(); hs_pc.delete();
    nd0 = n_done;
    do_start(sc);
    wait_end(20);
    tick();
    start = 1'b1; load_valid = 1'b1; load_data = 32'h002081B3;
    tick();
    start = 1'b0; load_valid = 1'b0;
    tick();
    $display("illegal: issues=%0d error=%0d err_pc=%0d", hs_word.size(), error, err_pc);
    check("ill_issue_count", hs_word.size(), 32'd1);
    check("ill_error", 32'(error), 32'd1);
    check("ill_err_pc", 32'(err_pc), 32'd1);
    check("ill_no_done", n_done, nd0);
    check("ill_count_kept", 32'(instr_count), 32'd2);
    do_clear();
    $display("after clear: error=%0d count=%0d", error, instr_count);
    check("ill_clear_error", 32'(error), 32'd0);
    check("ill_clear_count", 32'(instr_count), 32'd0);

    // Full buffer: offer 33 words back to back
    n_acc = 0;
    load_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      load_data = mkw(i);
      tick();
    end
    load_valid = 1'b0;
    $display("full buffer: accepted=%0d count=%0d load_ready=%0d", n_acc, instr_count, load_ready);
    check("full_accepted", n_acc, 32'd32);
    check("full_count", 32'(instr_count), 32'd32);
    check("full_load_ready", 32'(load_ready), 32'd0);
    hs_word.delete(); hs_pc.delete();
    nd0 = n_done;
    do_start(sc);
    wait_end(200);
    $display("full run: issues=%0d done_cyc=%0d start_cyc=%0d", hs_word.size(), done_cyc, sc);
    check("full_issue_count", hs_word.size(), 32'd32);
    check("full_done", n_done, nd0 + 1);
    check("full_done_time", done_cyc, sc + 64 + 1);
    for (int i = 0; i < 32; i++) begin
      if (i < hs_word.size()) begin
        check("full_pc", hs_pc[i], i);
        check("full_word", hs_word[i], mkw(i));
      end
    end

    // Empty start and priorities
    tick();
    do_clear();
    do_start(sc);
    $display("empty start: done=%0d busy=%0d", done, busy);
    check("empty_done_next", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    tick();
    load_word(32'h002081B3);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    $display("start+clear: busy=%0d count=%0d", busy, instr_count);
    check("sc_busy", 32'(busy), 32'd0);
    check("sc_count", 32'(instr_count), 32'd0);
    load_word(32'h002081B3);
    hs_word.delete(); hs_pc.delete();
    start = 1'b1; load_valid = 1'b1; load_data = 32'h401182B3;
    tick();
    start = 1'b0; load_valid = 1'b0;
    check("sl_busy", 32'(busy), 32'd1);
    check("sl_count", 32'(instr_count), 32'd1);
    wait_end(20);
    $display("start+load: issues=%0d count=%0d", hs_word.size(), instr_count);
    check("sl_issue_count", hs_word.size(), 32'd1);
    if (hs_word.size() >= 1) check("sl_word", hs_word[0], 32'h002081B3);

    // Reset in the middle of an issue
    tick();
    issue_ready = 1'b0;
    nd0 = n_done;
    do_start(sc);
    tick();
    check("mr_in_issue", 32'(issue_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-run: valid=%0d busy=%0d count=%0d", issue_valid, busy, instr_count);
    check("mr_valid", 32'(issue_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_count", 32'(instr_count), 32'd0);
    issue_ready = 1'b1;
    repeat (4) tick();
    check("mr_no_done", n_done, nd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_issue_ctrl.md
# riscv_issue_ctrl

Instruction buffer and issue sequencer for the R-type datapath. It accepts 32-bit instruction words over a load handshake into an internal buffer. On `start` it fetches them in order, decodes each into opcode, rd, funct3, rs1, rs2 and funct7, and issues them to the R-type ALU over a valid/ready handshake. It replaces free-running decode with an explicit, back-pressurable sequence that reports completion and illegal opcodes.

## Interface
- `WIDTH`, 32: instruction word width. Only 32 is supported.
- `DEPTH`, 32: buffer entries. Must be a power of two.
- `AW`, 5: pointer width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clear`  in  1  empties the buffer (count <- 0) and exits ERROR.
- `load_valid`  in  1  an instruction word is offered.
- `load_data`  in  WIDTH  instruction word.
- `load_ready`  out  1  buffer accepts a word this cycle.
- `start`  in  1  begin executing the buffered program.
- `issue_valid`  out  1  decoded instruction fields are valid.
- `issue_ready`  in  1  ALU accepts the instruction.
- `opcode` out 7, `rd` out 5, `funct3` out 3, `rs1` out 5, `rs2` out 5, `funct7` out 7: decoded fields, registered.
- `issue_pc`  out  AW  buffer index of the issued instruction.
- `instr_count`  out  AW+1  number of words currently buffered.
- `busy`  out  1  high in FETCH or ISSUE.
- `done`  out  1  one-cycle pulse when the program completes.
- `error`  out  1  high while in ERROR.
- `err_pc`  out  AW  index of the offending instruction.

## Operation
- States: IDLE, FETCH, ISSUE, DONE, ERROR.
- `load_ready` = (state==IDLE) && (count<DEPTH) && !start && !clear.
  - Load accept: write `buf[count]`, then count++.
  - Buffer contents are retained across runs, so `start` re-runs the same program.
- IDLE transitions:
  - `clear` -> count <- 0; remain IDLE. `clear` has priority over `start`.
  - `start` with count==0 -> DONE.
  - `start` with count>0 -> pc <- 0, go to FETCH.
- FETCH: registered read of `buf[pc]`; the fields are decoded into the output registers.
  - If word[6:0] != 7'b0110011 -> err_pc <- pc, go to ERROR. Nothing is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - `issue_valid` = 1. Fields and `issue_pc` are held stable until `issue_ready`.
  - On handshake with pc==count-1 -> DONE.
  - On handshake otherwise -> pc++, go to FETCH.
- DONE: `done` = 1 for this single cycle, pc <- 0, then IDLE.
- ERROR:
  - `error` = 1; `issue_valid` = 0.
  - `start` and `load_valid` are ignored.
  - `clear` -> count <- 0, go to IDLE.
- Outside IDLE: `start` is ignored; `load_ready` = 0.
- `clear` outside IDLE and ERROR is ignored.
- Field slicing:
  - opcode = [6:0], rd = [11:7], funct3 = [14:12]
  - rs1 = [19:15], rs2 = [24:20], funct7 = [31:25]
- The pc and count comparisons use AW+1 bits; a count of DEPTH does not wrap.

## Timing
- Reset values:
  - state IDLE; count 0, pc 0.
  - All field outputs, `issue_pc`, and `err_pc` are 0.
  - `issue_valid`, `done`, `error`, and `busy` are 0.
  - `load_ready` is 1 (when `start` and `clear` are low).
  - Buffer RAM is not reset.
- Reset mid-operation: the next cycle is IDLE with count 0. Any in-flight issue is dropped with no `done`.
- `start` sampled at cycle T: FETCH at T+1, first `issue_valid` at T+2.
- With `issue_ready` held at 1: one instruction every 2 cycles.
- `done` asserts the cycle after the final handshake.
- `start` with count==0 at T: `done` at T+1.
- Load throughput: 1 word per cycle.

## Test plan
- Basic run: load 0x002081B3 then 0x401182B3; pulse `start`; `issue_ready`=1.
  - Issue 0: rd=3, rs1=1, rs2=2, funct7=0, pc=0.
  - Issue 1: rd=5, rs1=3, rs2=1, funct7=0x20, pc=1.
  - `done` at start+5; `instr_count`=2 throughout.
- Backpressure: same program, `issue_ready` held low 4 cycles at issue 0.
  - `issue_valid` stays 1 and fields stay stable for all 4 cycles.
  - Completion is delayed by exactly 4 cycles.
- Illegal opcode: load 0x002081B3 then 0x00108093; `start`.
  - One issue occurs.
  - Then `error`=1, `err_pc`=1, no `done`.
  - `clear` -> IDLE, `instr_count`=0.
- Full buffer: offer 33 words continuously.
  - 32 accepted.
  - `load_ready`=0 once `instr_count`=32.
  - Run issues pc 0..31, then `done`.
- Empty start and priority:
  - `start` with count 0 -> `done` next cycle.
  - `start`+`clear` together -> stays IDLE, count 0.
  - `start`+`load_valid` together -> no word accepted.
- Reset mid-run: assert `rst` while in ISSUE.
  - Next cycle: `issue_valid`=0, `busy`=0, `instr_count`=0.
  - No `done` pulse.
